// File: rtl/neo_f0_pkg.sv
// Shared definitions for the NEO-F0 slot select / LED latch block.
package neo_f0_pkg;

  // Register select encodings driven by NEO-C1
  localparam logic [1:0] REG_SLOT       = 2'b00;
  localparam logic [1:0] REG_LEDLATCHES = 2'b01;
  localparam logic [1:0] REG_LEDDATA    = 2'b10;

  // LED shifter FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_LATCH    = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  // Active-low one-hot decode of a slot index; out-of-range ids select nothing
  function automatic logic [7:0] slot_onehot_n(input int unsigned id, input int unsigned count);
    logic [7:0] r;
    r = '1;
    if (id < count && id < 8) r[id[2:0]] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/neo_led_shifter.sv
// Serial LED latch shifter: queues latch requests, shifts the data register
// out MSB first on led_clk, then pulses the selected device's latch line.
module neo_led_shifter
  import neo_f0_pkg::*;
#(
  parameter int LED_LATCHES = 2,
  parameter int LED_BITS    = 8,
  parameter int SHIFT_DIV   = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_wr,
  input  logic [LED_BITS-1:0]    data_in,
  input  logic                   mask_wr,
  input  logic [LED_LATCHES-1:0] mask_in,
  output logic                   led_clk,
  output logic                   led_data,
  output logic [LED_LATCHES-1:0] led_latch,
  output logic                   busy
);

  localparam int DIV_W = $clog2(SHIFT_DIV + 1);
  localparam int CNT_W = (LED_BITS > 1) ? $clog2(LED_BITS) : 1;
  localparam int SEL_W = (LED_LATCHES > 1) ? $clog2(LED_LATCHES) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SHIFT_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(LED_BITS - 1);

  logic [2:0]             state;
  logic [DIV_W-1:0]       div;
  logic [CNT_W-1:0]       bitcnt;
  logic [LED_BITS-1:0]    data_reg;
  logic [LED_BITS-1:0]    shreg;
  logic [LED_BITS-1:0]    shifted;
  logic [LED_LATCHES-1:0] pending;
  logic [LED_LATCHES-1:0] clr_mask;
  logic [SEL_W-1:0]       low_idx;
  logic [SEL_W-1:0]       sel;

  assign shifted  = shreg << 1;
  assign clr_mask = (state == ST_LOAD) ? (LED_LATCHES'(1) << low_idx) : '0;

  // Lowest pending device wins (priority toward latch 0)
  always_comb begin
    low_idx = '0;
    for (int i = LED_LATCHES - 1; i >= 0; i--)
      if (pending[i]) low_idx = SEL_W'(i);
  end

  // Data register: host may rewrite freely; LOAD takes a snapshot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       data_reg <= '0;
    else if (data_wr) data_reg <= data_in;

  // Pending mask: LOAD clears its bit first, so a same-cycle write can re-arm it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | (mask_wr ? mask_in : '0);

  // Transfer sequencer: divider, bit counter, shift register and device select
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      div      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      led_data <= 1'b0;
      sel      <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (|pending) state <= ST_LOAD;
        ST_LOAD: begin
          shreg    <= data_reg;
          bitcnt   <= BIT_LOAD;
          led_data <= data_reg[LED_BITS-1];
          sel      <= low_idx;
          div      <= DIV_LOAD;
          state    <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO:
          if (div == '0) begin
            div   <= DIV_LOAD;
            state <= ST_SHIFT_HI;
          end else div <= div - 1'b1;
        ST_SHIFT_HI:
          if (div == '0) begin
            div <= DIV_LOAD;
            if (bitcnt == '0) begin
              led_data <= 1'b0;
              state    <= ST_LATCH;
            end else begin
              shreg    <= shifted;
              led_data <= shifted[LED_BITS-1];
              bitcnt   <= bitcnt - 1'b1;
              state    <= ST_SHIFT_LO;
            end
          end else div <= div - 1'b1;
        ST_LATCH:
          if (div == '0) begin
            div   <= DIV_LOAD;
            state <= ST_GAP;
          end else div <= div - 1'b1;
        ST_GAP:
          if (div == '0) state <= (|pending) ? ST_LOAD : ST_IDLE;
          else           div   <= div - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end

  assign led_clk   = (state != ST_SHIFT_LO);
  assign led_latch = (state == ST_LATCH) ? (LED_LATCHES'(1) << sel) : '0;
  assign busy      = (state != ST_IDLE) | (|pending);

endmodule

// File: rtl/neo_f0_slotled.sv
// NEO-F0 slot select register and decode, plus the serial LED latch path.
module neo_f0_slotled
  import neo_f0_pkg::*;
#(
  parameter int SLOT_COUNT  = 6,
  parameter int SLOT_BITS   = 3,
  parameter int LED_LATCHES = 2,
  parameter int LED_BITS    = 8,
  parameter int SHIFT_DIV   = 12
) (
  input  logic                   CLK_24M,
  input  logic                   nRESET,
  input  logic                   nREGWR,
  input  logic [1:0]             REG_SEL,
  input  logic [7:0]             WDATA,
  output logic [SLOT_COUNT-1:0]  nSLOT,
  output logic [SLOT_BITS-1:0]   SLOT_ID,
  output logic                   LED_CLK,
  output logic                   LED_DATA,
  output logic [LED_LATCHES-1:0] LED_LATCH,
  output logic                   BUSY
);

  logic                 slot_wr;
  logic                 led_data_wr;
  logic                 led_mask_wr;
  logic [SLOT_BITS-1:0] wr_slot;

  assign slot_wr     = !nREGWR && (REG_SEL == REG_SLOT);
  assign led_mask_wr = !nREGWR && (REG_SEL == REG_LEDLATCHES);
  assign led_data_wr = !nREGWR && (REG_SEL == REG_LEDDATA);
  assign wr_slot     = WDATA[SLOT_BITS-1:0];

  // Slot register: out-of-range writes fall back to slot 0
  always_ff @(posedge CLK_24M or negedge nRESET)
    if (!nRESET)      SLOT_ID <= '0;
    else if (slot_wr) SLOT_ID <= (32'(wr_slot) < SLOT_COUNT) ? wr_slot : '0;

  assign nSLOT = SLOT_COUNT'(slot_onehot_n(32'(SLOT_ID), SLOT_COUNT));

  neo_led_shifter #(
    .LED_LATCHES (LED_LATCHES),
    .LED_BITS    (LED_BITS),
    .SHIFT_DIV   (SHIFT_DIV)
  ) u_shifter (
    .clk       (CLK_24M),
    .rst_n     (nRESET),
    .data_wr   (led_data_wr),
    .data_in   (WDATA[LED_BITS-1:0]),
    .mask_wr   (led_mask_wr),
    .mask_in   (WDATA[LED_LATCHES-1:0]),
    .led_clk   (LED_CLK),
    .led_data  (LED_DATA),
    .led_latch (LED_LATCH),
    .busy      (BUSY)
  );

endmodule
